// File: rtl/mux_pipe_param_if.sv
// Handshake bundle for mux_pipe_param: K packed input lanes with select/mode
// on the upstream side and one registered lane result on the downstream side.
interface mux_pipe_param_if #(
    parameter int N = 4,
    parameter int K = 4
);
    localparam int SEL_W = $clog2(K);

    logic [K*N-1:0]   in_data;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic             mode;
    logic [N-1:0]     out_data;
    logic [SEL_W-1:0] out_sel;
    logic             out_err;
    logic             out_valid;
    logic             out_ready;

    // Producer/consumer side: offers transfers and accepts results.
    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_sel, out_err, out_valid
    );

    // Multiplexer side.
    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_sel, out_err, out_valid
    );
endinterface

// File: rtl/mux_pipe_param.sv
// Pipelined K:1 lane multiplexer with a one-deep registered output.
// Lane choice is either an explicit select or an internal round-robin
// pointer; an out-of-range explicit select yields a flagged zero result.
module mux_pipe_param #(
    parameter int N = 4,
    parameter int K = 4
) (
    input logic             clk,
    input logic             rst,
    mux_pipe_param_if.slave bus
);
    localparam int SEL_W = $clog2(K);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_next;
    logic [SEL_W-1:0] idx;
    logic [N-1:0]     lane_data;
    logic             sel_range_bad;
    logic             bad;
    logic             in_fire;
    logic             out_fire;

    logic [N-1:0]     data_q;
    logic [SEL_W-1:0] sel_q;
    logic             err_q;
    logic             valid_q;

    // A select can only exceed the lane count when K is not a power of two.
    if ((1 << SEL_W) == K) begin : g_pow2
        assign sel_range_bad = 1'b0;
    end else begin : g_npow2
        assign sel_range_bad = (bus.sel > SEL_W'(K - 1));
    end

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = valid_q && bus.out_ready;
    assign bus.in_ready  = !valid_q || bus.out_ready;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_err   = err_q;
    assign bus.out_valid = valid_q;

    // Effective lane index, wrap-around pointer successor and lane extraction.
    always_comb begin
        idx       = bus.mode ? rr_ptr : bus.sel;
        bad       = !bus.mode && sel_range_bad;
        rr_next   = (rr_ptr == SEL_W'(K - 1)) ? '0 : rr_ptr + SEL_W'(1);
        lane_data = '0;
        for (int i = 0; i < K; i++) begin
            if (idx == SEL_W'(i)) begin
                lane_data = bus.in_data[i*N +: N];
            end
        end
    end

    // Output register and round-robin pointer; registers load only on an accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            rr_ptr  <= '0;
        end else begin
            if (in_fire) begin
                valid_q <= 1'b1;
                if (bad) begin
                    data_q <= '0;
                    sel_q  <= bus.sel;
                    err_q  <= 1'b1;
                end else begin
                    data_q <= lane_data;
                    sel_q  <= idx;
                    err_q  <= 1'b0;
                end
                if (bus.mode) begin
                    rr_ptr <= rr_next;
                end
            end else if (out_fire) begin
                valid_q <= 1'b0;
            end
        end
    end
endmodule
